mac_seq_ctrl: RTL
=================

# mac_seq_ctrl

Parametrised sequencer for the multiply-accumulate datapath: runs a programmable number of multiply/accumulate terms per job and drives accumulator clear, operand load, multiplier start and accumulate strobes. It adds a runtime term count, an auto-advance mode, an abort input, a term index, a done pulse and an optional multiplier watchdog. It sits between the host/test interface and the multiplier plus accumulator.

## Interface
- `CNT_W`, 4: width of `n_terms`, the remaining-term counter and `term_idx`.
- `TIMEOUT_CYC`, 15: maximum `TEST` cycles without `mul_done`; used only with the watchdog macro.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  job request, sampled in `IDLE`.
- `n_terms`  in  CNT_W  products in the job; latched when `start` is accepted.
- `auto_mode`  in  1  latched with `start`; 1 = skip `WAIT` between terms.
- `do_next`  in  1  level input; a rising edge advances out of `WAIT`.
- `mul_done`  in  1  multiplier-complete flag, sampled only in `TEST`.
- `abort`  in  1  cancels the job.
- `finish`  out  1  high in `IDLE`.
- `busy`  out  1  inverse of `finish`.
- `clr_acc_n`  out  1  active-low accumulator clear; low in `INIT` or whenever `reset` = 0 (combinational).
- `load_op`  out  1  high in `LOAD`.
- `begin_mul`  out  1  high in `RUN`.
- `add`  out  1  high in `ADD`.
- `done_pulse`  out  1  high in `DONE`.
- `term_idx`  out  CNT_W  0-based index of the current term.
- `error`  out  1  sticky watchdog flag.

## Operation
- States: `IDLE`, `INIT`, `LOAD`, `RUN`, `TEST`, `ADD`, `WAIT`, `DONE`, encoded in 3 bits. Any unused encoding goes to `IDLE`.
- `IDLE`:
  - `start` = 1 and `abort` = 0 → `INIT`.
  - On that transition, latch `n_terms` into `rem` and `auto_mode`; clear `term_idx` and `error`.
- `INIT` → `DONE` if `rem` = 0 (clear-only job), else → `LOAD`.
- `LOAD` → `RUN` → `TEST`.
- `TEST`: stay while `mul_done` = 0; `mul_done` = 1 → `ADD`.
- `ADD`:
  - `rem` = 1 → `DONE`.
  - Otherwise `rem` decrements; go to `LOAD` if auto mode is latched, else `WAIT`.
  - `term_idx` increments on every `ADD` exit except the exit to `DONE`.
- `WAIT`: `do_next` = 1 with the previous-cycle `do_next` = 0 → `LOAD`.
  - Edge register updates every cycle, reset to 0.
  - Edges outside `WAIT` are discarded; a held-high `do_next` does not retrigger.
- `DONE` → `IDLE`.
- Priority: reset > `abort` > watchdog > normal transition.
- `abort` in any non-`IDLE` state → `IDLE` next cycle. No `done_pulse`; `error` unchanged; `term_idx` holds.
- `abort` = 1 in `IDLE` blocks `start`.
- Ignored inputs: `start` while busy; `mul_done` outside `TEST`; `n_terms` and `auto_mode` changes mid-job.
- Arithmetic: `rem` and `term_idx` are CNT_W unsigned. Maximum job is 2^CNT_W−1 terms, so no wrap is possible.

## Timing
- Reset values (cycle after `reset` low at an edge): state `IDLE`, `finish` = 1, `busy` = 0, `load_op`/`begin_mul`/`add`/`done_pulse` = 0, `term_idx` = 0, `rem` = 0, `error` = 0. `clr_acc_n` = 0 during reset and 1 after.
- Reset mid-job behaves identically; no strobe is emitted in the cycle after.
- Single-term job, `mul_done` already high, `start` at cycle 0: `INIT`@1, `LOAD`@2, `RUN`@3, `TEST`@4, `ADD`@5, `DONE`@6, `IDLE`@7.
- Per term in auto mode: 3 + k cycles, where k ≥ 1 is the number of `TEST` cycles.
- Manual mode adds `WAIT` cycles until the edge; `LOAD` follows the edge cycle by 1 cycle.
- All outputs are Moore decodes of the registered state, except `clr_acc_n`.

## Configuration
- `MAC_CTRL_TIMEOUT_EN` defined:
  - A cycle counter resets on `TEST` entry.
  - On the TIMEOUT_CYC-th consecutive `TEST` cycle with `mul_done` = 0, set `error` and go to `IDLE` next cycle. No `add`, no `done_pulse`.
  - `error` stays set until the next accepted `start` or reset.
- `MAC_CTRL_TIMEOUT_EN` undefined: `TEST` waits indefinitely, `error` is tied 0, and `TIMEOUT_CYC` is unused.

## Test plan
- Reset, then `start` with `n_terms` = 1 and `mul_done` high → states follow cycles 1–7 as in Timing; exactly one `add` and one `done_pulse`; `term_idx` = 0.
- `n_terms` = 3, auto, `mul_done` after 2 `TEST` cycles → 3 `add` pulses 5 cycles apart; `term_idx` 0, 1, 2; `done_pulse` once.
- `n_terms` = 2, manual: hold `do_next` high before `WAIT`, then drop and raise it → held level ignored; `LOAD` 1 cycle after the new edge.
- `n_terms` = 0 → `clr_acc_n` low 1 cycle, then `DONE`, no `load_op`. Separately, `abort` during `TEST` → `IDLE` next cycle, no `done_pulse`.
- With macro and `TIMEOUT_CYC` = 15, `mul_done` never asserted → `error` = 1 and `IDLE` after 15 `TEST` cycles; next `start` clears `error`. Without macro → stays in `TEST`.
- Reset asserted in `WAIT` with `term_idx` = 2 → next cycle `IDLE`, `term_idx` = 0, all strobes 0.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Multiply-accumulate job sequencer: drives clear/load/start/add strobes for n_terms products.
// Optional multiplier watchdog enabled by defining MAC_CTRL_TIMEOUT_EN.
module mac_seq_ctrl #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             auto_mode,
    input  logic             do_next,
    input  logic             mul_done,
    input  logic             abort,
    output logic             finish,
    output logic             busy,
    output logic             clr_acc_n,
    output logic             load_op,
    output logic             begin_mul,
    output logic             add,
    output logic             done_pulse,
    output logic [CNT_W-1:0] term_idx,
    output logic             error
);

    typedef enum logic [2:0] {
        StIdle, StInit, StLoad, StRun, StTest, StAdd, StWait, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             auto_q, auto_d;
    logic             dn_q;

`ifdef MAC_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    logic          timeout;

    // tcnt holds the number of TEST cycles already spent before the current one
    assign timeout = (state_q == StTest) && !mul_done && (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        auto_d  = auto_q;
`ifdef MAC_CTRL_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        if (state_q != StIdle && abort) begin
            state_d = StIdle;
        end
`ifdef MAC_CTRL_TIMEOUT_EN
        else if (timeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end
`endif
        else begin
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_d = StInit;
                        rem_d   = n_terms;
                        auto_d  = auto_mode;
                        idx_d   = '0;
`ifdef MAC_CTRL_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                StInit:  state_d = (rem_q == '0) ? StDone : StLoad;
                StLoad:  state_d = StRun;
                StRun: begin
                    state_d = StTest;
`ifdef MAC_CTRL_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
                StTest: begin
                    if (mul_done) begin
                        state_d = StAdd;
                    end
`ifdef MAC_CTRL_TIMEOUT_EN
                    else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
`endif
                end
                StAdd: begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        rem_d   = rem_q - CNT_W'(1);
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = auto_q ? StLoad : StWait;
                    end
                end
                StWait:  if (do_next && !dn_q) state_d = StLoad;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            idx_q   <= '0;
            auto_q  <= 1'b0;
            dn_q    <= 1'b0;
`ifdef MAC_CTRL_TIMEOUT_EN
            tcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            auto_q  <= auto_d;
            dn_q    <= do_next;
`ifdef MAC_CTRL_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign finish     = (state_q == StIdle);
    assign busy       = ~finish;
    assign clr_acc_n  = reset && (state_q != StInit);
    assign load_op    = (state_q == StLoad);
    assign begin_mul  = (state_q == StRun);
    assign add        = (state_q == StAdd);
    assign done_pulse = (state_q == StDone);
    assign term_idx   = idx_q;
`ifdef MAC_CTRL_TIMEOUT_EN
    assign error      = err_q;
`else
    assign error      = 1'b0;
`endif

endmodule
